// File: rtl/tappu_instr_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tappu_instr_loader_if                                     |
// | Brief    : valid/ready word channel from the loader to the core      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface tappu_instr_loader_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface
`default_nettype wire

// File: rtl/tappu_instr_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tappu_instr_loader                                        |
// | Brief    : strobe-synchronised byte assembler feeding a FWFT FIFO    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tappu_instr_loader #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 2,
  parameter int DEPTH      = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_stb_raw,
  input  wire logic [BYTE_W-1:0]          i_din,
  input  wire logic                       i_flush,
  tappu_instr_loader_if.master            bus,
  output logic [$clog2(DEPTH+1)-1:0]      o_level,
  output logic                            o_busy,
  output logic                            o_overflow
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int PART_W = WORD_W - BYTE_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(WORD_BYTES);
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic                r_s1, r_s2, r_s3;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [PART_W-1:0]   r_partial;
  logic [PTR_W:0]      r_wr_cnt, r_rd_cnt;
  logic                r_overflow;
  logic [WORD_W-1:0]   r_mem [DEPTH];

  logic                w_rise, w_cap, w_last;
  logic [WORD_W-1:0]   w_word;
  logic [PTR_W:0]      w_level;
  logic                w_full, w_empty, w_pop, w_push_req, w_push, w_drop;

  // Sync chain idles high so a strobe already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_stb_raw;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_comb begin
    w_rise     = r_s2 & ~r_s3;
    w_cap      = w_rise & ~i_flush;
    w_last     = (r_byte_cnt == CNT_W'(WORD_BYTES - 1));
    w_word     = {i_din, r_partial};
    w_level    = r_wr_cnt - r_rd_cnt;
    w_full     = (w_level == (PTR_W+1)'(DEPTH));
    w_empty    = (w_level == '0);
    w_pop      = ~w_empty & bus.word_ready & ~i_flush;
    w_push_req = w_cap & w_last;
    // A full FIFO still takes the word when the head leaves on the same edge.
    w_push     = w_push_req & (~w_full | w_pop);
    w_drop     = w_push_req & w_full & ~w_pop;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_byte_cnt <= '0;
      r_partial  <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_cap) begin
        if (w_last) begin
          r_byte_cnt <= '0;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_partial[int'(r_byte_cnt)*BYTE_W +: BYTE_W] <= i_din;
        end
      end
      if (w_push) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_cnt[PTR_W-1:0]] <= w_word;
  end

  always_comb begin
    bus.word_data  = r_mem[r_rd_cnt[PTR_W-1:0]];
    bus.word_valid = ~w_empty;
    o_level        = LVL_W'(w_level);
    o_busy         = (r_byte_cnt != '0);
    o_overflow     = r_overflow;
  end

endmodule
`default_nettype wire
